// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
// Pops bytes from a synchronous FIFO (registered dout, lagging empty flag) and
// serializes each one as an asynchronous UART frame: start bit, data LSB-first,
// optional parity bit, then one or two stop bits. All outputs are registered.
// Each popped byte occupies a full frame of at least ten bit times, so the
// FIFO's lagging empty flag has long settled by the next IDLE sample.
`timescale 1ns/1ps

module uart_tx_fifo_drain #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic              r_tx;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] w_shift_d;
    logic              w_tx_nxt;
    logic              w_done_nxt;
    logic              w_in_bit;
    logic              w_bit_end;
    logic              w_data_last;
    logic              w_stop_last;
    logic              w_parity;

    // Timing helpers: a serial bit ends when the baud counter reaches its last count.
    assign w_in_bit    = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_bit_end   = w_in_bit && (r_baud == BAUD_LAST);
    assign w_data_last = (r_bit == DATA_LAST);
    assign w_stop_last = (r_bit == STOP_LAST);
    assign w_parity    = (^fifo_dout) ^ (PARITY_ODD != 0);

    // Next-state decode for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (enable && !fifo_empty) w_state_nxt = S_POP;
            S_POP:    w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_bit_end && w_data_last)
                    w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end && w_stop_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next shift-register contents and the line level / done pulse for the coming cycle.
    always_comb begin
        w_shift_d = r_shift;
        if (r_state == S_LOAD)
            w_shift_d = fifo_dout;
        else if (r_state == S_DATA && w_bit_end)
            w_shift_d = r_shift >> 1;

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_d[0];
            S_PARITY: w_tx_nxt = r_parity;
            default:  w_tx_nxt = 1'b1;
        endcase

        // Counter is one short of the last count while in the final stop bit.
        w_done_nxt = (r_state == S_STOP) && (r_baud == BAUD_PRE) && w_stop_last;
    end

    // Sequencer state; reset abandons any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Baud counter: runs only in the serial states and restarts at every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_baud <= '0;
        else if (!w_in_bit) r_baud <= '0;
        else if (w_bit_end) r_baud <= '0;
        else                r_baud <= r_baud + BAUD_W'(1);
    end

    // Bit counter: indexes data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit <= '0;
        end else if (w_bit_end) begin
            if ((r_state == S_DATA && !w_data_last) || (r_state == S_STOP && !w_stop_last))
                r_bit <= r_bit + BIT_W'(1);
            else
                r_bit <= '0;
        end
    end

    // Capture the popped byte and its parity in LOAD, then shift out LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
        end else begin
            r_shift <= w_shift_d;
            if (r_state == S_LOAD) r_parity <= w_parity;
        end
    end

    // Registered outputs, aligned with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_rd_en <= (w_state_nxt == S_POP);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign tx         = r_tx;
    assign fifo_rd_en = r_rd_en;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Downstream consumer of the team's synchronous FIFO (rd_en / dout / empty interface). It pops one byte at a time from the FIFO and serializes it as an asynchronous UART frame: start bit, data LSB-first, optional parity, and 1 or 2 stop bits. It sits between the TX FIFO and the device pin. It tolerates the FIFO's registered dout and its lagging empty flag.

Parameters:
DATA_W, 8, data bits per frame; must match the FIFO DATA_W
CLKS_PER_BIT, 868, clk cycles per serial bit; legal range >= 2
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
enable  in  1  allows new frames to start; sampled only in IDLE
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  DATA_W  FIFO read data, registered by the FIFO
fifo_rd_en  out  1  single-cycle pop strobe to the FIFO
tx  out  1  serial line; idle high
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse on the last stop-bit cycle

Behaviour:
- Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0. All outputs are registered.
- State machine: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1. Transition to POP when enable=1 and fifo_empty=0.
- POP: lasts exactly 1 cycle; fifo_rd_en=1 during this cycle only. Transition to LOAD.
- LOAD: lasts 1 cycle. fifo_dout is valid here because the FIFO registers dout at the edge ending POP. Capture fifo_dout into the shift register and compute parity (XOR of the data bits, inverted if PARITY_ODD). Transition to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles. A bit counter of width $clog2(DATA_W)+1 counts 0..DATA_W-1.
- PARITY: entered only if PARITY_EN=1. tx=parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 on the final cycle of STOP. Transition to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is cleared on entry to START.
- Frame length from first START cycle to last STOP cycle: (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Back-to-back frames: the IDLE, POP and LOAD cycles give exactly 3 tx-high cycles between the last stop cycle and the next start bit.
- FIFO empty lag: the FIFO empty flag settles 2 cycles after a pop. The block re-samples fifo_empty only in IDLE, at least 10*CLKS_PER_BIT cycles after the previous pop, so it never pops a stale or empty FIFO.
- Pop guard: fifo_rd_en is never asserted while fifo_empty=1 is sampled in IDLE.
- enable deasserted mid-frame: the current frame completes unchanged. No new pop occurs until enable=1.
- fifo_empty rising mid-frame: no effect on the current frame.
- Reset mid-frame: tx=1 immediately (asynchronous). The byte in flight is discarded, not re-read. State returns to IDLE.
- busy: 1 from the POP cycle through the last STOP cycle inclusive.

Test Plan:
- Single byte (CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1): FIFO holds 0xA5, enable=1 -> one fifo_rd_en pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total); frame_done pulses once; tx=1 afterward; FIFO empty.
- Back-to-back: FIFO holds 0x01, 0x80, 0xFF -> exactly 3 rd_en pulses; exactly 3 tx-high cycles between frames; data serialized in order; no fourth pop.
- Parity: PARITY_EN=1, byte 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame is 44 cycles at CLKS_PER_BIT=4; STOP_BITS=2 adds 4 cycles.
- Empty/enable: fifo_empty=1 for 100 cycles -> no rd_en, tx=1, busy=0. Then enable=0 with data present -> no pop. Drop enable during DATA -> frame completes, no further pop.
- Reset mid-frame: assert rst during data bit 3 -> tx=1, busy=0 the same cycle. After release with FIFO non-empty -> next frame carries the next FIFO entry; the interrupted byte is not resent.
- Random soak: 200 random bytes with random enable gaps, decoded by a bench UART model -> byte stream identical; rd_en never asserted while fifo_empty=1.
